// File: rtl/snn_pkg.sv
// Shared constants and state encodings for the SNN input loader and its UART receiver.
package snn_pkg;

  localparam int IMG_BITS         = 784;
  localparam int ADDR_W           = 10;
  localparam int BAUD_DIV_DEFAULT = 434;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_WAIT_BYTE,
    ST_START,
    ST_WAIT_DONE
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/snn_input_loader_uart_rx.sv
// 8N1 UART receiver, LSB first: 2-flop synchronizer, mid-bit sampling, stop-bit framing check.
module uart_rx
  import snn_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam logic [15:0] HALF_RELOAD = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_RELOAD = 16'(BAUD_DIV - 1);

  logic        rxd_meta_reg;
  logic        rxd_sync_reg;
  logic        rxd_prev_reg;
  rx_state_t   state_reg;
  logic [15:0] cnt_reg;
  logic [2:0]  bit_idx_reg;
  logic [7:0]  shift_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
      rxd_prev_reg <= 1'b1;
      state_reg    <= RX_IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      rx_valid     <= 1'b0;
      rx_byte      <= '0;
      frame_err    <= 1'b0;
    end else begin
      rxd_meta_reg <= rxd;
      rxd_sync_reg <= rxd_meta_reg;
      rxd_prev_reg <= rxd_sync_reg;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      case (state_reg)
        RX_IDLE: begin
          if (rxd_prev_reg && !rxd_sync_reg) begin
            cnt_reg   <= HALF_RELOAD;
            state_reg <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_reg != 16'd0) begin
            cnt_reg <= cnt_reg - 16'd1;
          end else if (rxd_sync_reg) begin
            // line back high at mid start bit: a glitch, not a character
            state_reg <= RX_IDLE;
          end else begin
            cnt_reg     <= FULL_RELOAD;
            bit_idx_reg <= '0;
            state_reg   <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (cnt_reg != 16'd0) begin
            cnt_reg <= cnt_reg - 16'd1;
          end else begin
            shift_reg   <= {rxd_sync_reg, shift_reg[7:1]};
            cnt_reg     <= FULL_RELOAD;
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (cnt_reg != 16'd0) begin
            cnt_reg <= cnt_reg - 16'd1;
          end else begin
            if (rxd_sync_reg) begin
              rx_valid <= 1'b1;
              rx_byte  <= shift_reg;
            end else begin
              frame_err <= 1'b1;
            end
            state_reg <= RX_IDLE;
          end
        end
        default: state_reg <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/snn_input_loader.sv
// Loads a UART-delivered binary image into the SNN input RAM bit by bit, then starts the core.
// Optional inter-byte timeout is enabled by defining LOADER_TIMEOUT_EN.
module snn_input_loader #(
  parameter int BAUD_DIV       = snn_pkg::BAUD_DIV_DEFAULT,
  parameter int IMG_BITS       = snn_pkg::IMG_BITS,
  parameter int ADDR_W         = snn_pkg::ADDR_W,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              start,
  input  logic              core_done,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              timeout
);
  import snn_pkg::*;

  localparam int                BI_W      = ADDR_W - 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BITS - 1);

  logic        rx_valid;
  logic [7:0]  rx_byte;

  uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  loader_state_t     state_reg;
  logic [BI_W-1:0]   byte_idx_reg;
  logic [7:0]        byte_reg;
  logic [7:0]        hold_reg;
  logic              hold_valid_reg;
  logic [2:0]        bit_k_reg;
  logic              busy_reg;
  logic              start_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              data_reg;
  logic              overrun_reg;

  logic              unpack_last;
  logic              img_last;
  logic [BI_W-1:0]   idx_inc;
  logic              load_en;
  logic [7:0]        load_byte;
  logic [BI_W-1:0]   load_idx;

  assign unpack_last = (bit_k_reg == 3'd7);
  assign img_last    = (addr_reg == LAST_ADDR);
  assign idx_inc     = byte_idx_reg + 1'b1;

  // A new byte begins unpacking either from the receiver or, back to back, from the holding register.
  always_comb begin
    load_en   = 1'b0;
    load_byte = rx_byte;
    load_idx  = byte_idx_reg;
    case (state_reg)
      ST_IDLE: begin
        load_en  = rx_valid;
        load_idx = '0;
      end
      ST_WAIT_BYTE: load_en = rx_valid;
      ST_UNPACK: begin
        if (unpack_last && !img_last) begin
          load_idx = idx_inc;
          if (hold_valid_reg) begin
            load_en   = 1'b1;
            load_byte = hold_reg;
          end else begin
            load_en = rx_valid;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef LOADER_TIMEOUT_EN
  localparam logic [31:0] TIMER_LIMIT = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] timer_reg;
  logic        timeout_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      byte_idx_reg   <= '0;
      byte_reg       <= '0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      bit_k_reg      <= '0;
      busy_reg       <= 1'b0;
      start_reg      <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      timer_reg      <= '0;
      timeout_reg    <= 1'b0;
`endif
    end else begin
      start_reg <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      timeout_reg <= 1'b0;
      timer_reg   <= '0;
`endif
      case (state_reg)
        ST_IDLE: byte_idx_reg <= '0;
        ST_UNPACK: begin
          if (!unpack_last) begin
            bit_k_reg <= bit_k_reg + 3'd1;
            addr_reg  <= addr_reg + 1'b1;
            data_reg  <= byte_reg[1];
            byte_reg  <= {1'b0, byte_reg[7:1]};
            if (rx_valid) begin
              if (hold_valid_reg) begin
                overrun_reg <= 1'b1;
              end else begin
                hold_reg       <= rx_byte;
                hold_valid_reg <= 1'b1;
              end
            end
          end else begin
            we_reg   <= 1'b0;
            addr_reg <= '0;
            if (img_last) begin
              // image complete: anything still arriving belongs to no image
              start_reg      <= 1'b1;
              byte_idx_reg   <= '0;
              hold_valid_reg <= 1'b0;
              state_reg      <= ST_START;
              if (hold_valid_reg || rx_valid) begin
                overrun_reg <= 1'b1;
              end
            end else begin
              byte_idx_reg <= idx_inc;
              state_reg    <= ST_WAIT_BYTE;
              if (hold_valid_reg) begin
                hold_valid_reg <= rx_valid;
                if (rx_valid) begin
                  hold_reg <= rx_byte;
                end
              end
            end
          end
        end
        ST_WAIT_BYTE: begin
`ifdef LOADER_TIMEOUT_EN
          if (!rx_valid) begin
            if (timer_reg == TIMER_LIMIT) begin
              timeout_reg  <= 1'b1;
              byte_idx_reg <= '0;
              busy_reg     <= 1'b0;
              state_reg    <= ST_IDLE;
            end else begin
              timer_reg <= timer_reg + 32'd1;
            end
          end
`endif
        end
        ST_START: begin
          state_reg <= ST_WAIT_DONE;
          if (rx_valid) begin
            overrun_reg <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (rx_valid) begin
            overrun_reg <= 1'b1;
          end
          if (core_done) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (load_en) begin
        busy_reg  <= 1'b1;
        state_reg <= ST_UNPACK;
        we_reg    <= 1'b1;
        addr_reg  <= {load_idx, 3'b000};
        data_reg  <= load_byte[0];
        byte_reg  <= load_byte;
        bit_k_reg <= '0;
      end
    end
  end

  assign ram_data = data_reg;
  assign ram_addr = addr_reg;
  assign ram_we   = we_reg;
  assign start    = start_reg;
  assign busy     = busy_reg;
  assign overrun  = overrun_reg;
`ifdef LOADER_TIMEOUT_EN
  assign timeout  = timeout_reg;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: doc/snn_input_loader.md
# snn_input_loader

Upstream feeder for the SNN core. It receives a 28x28 binary image over a UART as 98 bytes (8N1, LSB first). It unpacks each byte into eight single-bit writes to the input-unit RAM (1024x1, addresses 0..783). When the last pixel is written, it pulses `start` to the core and holds off further loading until the core reports `done`.

## Interface
Parameters:
- `BAUD_DIV`, 434: clock cycles per UART bit; legal range 4..65535.
- `IMG_BITS`, 784: pixels per image; must be a multiple of 8.
- `ADDR_W`, 10: RAM address width.
- `TIMEOUT_CYCLES`, 5_000_000: inter-byte gap limit. Used only with `LOADER_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rst`, in, 1: asynchronous, active-high reset.
- `rxd`, in, 1: UART serial input; idles high; asynchronous to `clk`.
- `ram_data`, out, 1: pixel bit to the input-unit RAM.
- `ram_addr`, out, ADDR_W: pixel address.
- `ram_we`, out, 1: RAM write enable.
- `start`, out, 1: one-cycle pulse to the SNN core.
- `core_done`, in, 1: core finished classification; level or pulse accepted.
- `busy`, out, 1: high from the first byte of an image until `core_done` is seen.
- `frame_err`, out, 1: one-cycle pulse when a byte arrives with a bad stop bit.
- `overrun`, out, 1: sticky; set when a byte is dropped; cleared only by `rst`.
- `timeout`, out, 1: one-cycle pulse when an inter-byte gap times out. Tied 0 without the macro.

## Operation
UART receiver:
- `rxd` passes through a 2-flop synchronizer.
- A falling edge in idle starts a bit counter.
- Start bit is re-checked at BAUD_DIV/2; if `rxd` is high there, it is a false start and the receiver returns to idle.
- Data bits are sampled every BAUD_DIV cycles after that point; stop bit is sampled the same way.
- Stop bit = 1: `rx_valid` pulses one cycle with `rx_byte`.
- Stop bit = 0: `frame_err` pulses and the byte is discarded.

Loader FSM: IDLE, UNPACK, WAIT_BYTE, START, WAIT_DONE.
- IDLE: `byte_idx`=0. On `rx_valid`, latch the byte, set `busy`, go to UNPACK.
- UNPACK: 8 consecutive cycles with `ram_we`=1, `ram_addr`=byte_idx*8+k, `ram_data`=byte[k], k=0..7.
  - After k=7: if `ram_addr` was IMG_BITS-1, go to START; else increment `byte_idx` and go to WAIT_BYTE.
- WAIT_BYTE: on `rx_valid`, go to UNPACK.
- START: `start`=1 for exactly one cycle, then WAIT_DONE.
- WAIT_DONE: when `core_done`=1, clear `busy` and go to IDLE on the next cycle.

Boundary conditions:
- `rx_valid` during UNPACK: the byte goes into a one-entry holding register and is consumed on UNPACK exit, with no gap cycle. This cannot occur for BAUD_DIV>=4 at line rate; the register is a guard only.
- `rx_valid` with the holding register already full: byte dropped, `overrun` set.
- `rx_valid` in START or WAIT_DONE: byte dropped, `overrun` set. The next image always begins at address 0.
- `frame_err` never advances `byte_idx`.
- `rst` at any point: FSM to IDLE, all counters cleared, holding register emptied, receiver to idle. A partial image is abandoned.

## Timing
- Reset values: `ram_data`, `ram_addr`, `ram_we`, `start`, `busy`, `frame_err`, `overrun`, `timeout` all 0.
- `ram_addr` is 0 whenever `ram_we` is 0.
- Falling edge of `rxd` start bit to `rx_valid`: 2 + 9*BAUD_DIV + BAUD_DIV/2 cycles, ±1.
- `rx_valid` in cycle N: writes occur in cycles N+1..N+8.
- Final write (address IMG_BITS-1) in cycle M: `start` is high in cycle M+1.
- `core_done` seen in cycle D: `busy` goes low in cycle D+1.
- All outputs are registered.

## Configuration
`LOADER_TIMEOUT_EN`:
- Defined: a counter runs in WAIT_BYTE and resets on each `rx_valid`.
  - When it reaches TIMEOUT_CYCLES: `timeout` pulses one cycle, `byte_idx`=0, `busy`=0, FSM goes to IDLE.
  - Already-written RAM contents are left as-is.
- Undefined: no counter; `timeout` is tied 0; WAIT_BYTE waits indefinitely.

## Structure
- Shared package `snn_pkg`:
  - loader state enum,
  - `IMG_BITS`=784,
  - `ADDR_W`=10,
  - default `BAUD_DIV`.
- One sub-module, `uart_rx`: synchronizer, bit timing, framing check. Outputs `rx_valid`, `rx_byte`, `frame_err`.
- The FSM, holding register and timeout counter live in the top module.

## Test plan
All scenarios use BAUD_DIV=4 unless stated.
- 98 bytes of 0x01: exactly 784 writes; data=1 at addresses 0,8,...,776, 0 elsewhere; `start` high one cycle after the address-783 write.
- First byte 0xA5: addresses 0..7 written with 1,0,1,0,0,1,0,1 in cycles N+1..N+8 after `rx_valid`.
- Byte with stop bit 0: `frame_err` pulses, no `ram_we`; the next good byte writes addresses 0..7.
- 2 bytes sent during WAIT_DONE: `overrun`=1, no writes. Pulse `core_done`, send 1 byte: it writes addresses 0..7.
- `rst` asserted after 50 bytes: all outputs 0 immediately; the next byte writes addresses 0..7 and `start` never fires for the partial image.
- TIMEOUT_CYCLES=1000, gap of 1500 cycles after 10 bytes:
  - With the macro: `timeout` pulses and the next byte writes address 0.
  - Without the macro: no pulse and the next byte writes addresses 80..87.
